result_unload: RTL and testbench



---
 rtl/dataload_pkg.sv | 15 +
 rtl/piso_buffer.sv | 40 ++++
 rtl/result_unload.sv | 95 +++++++++
 tb/tb_result_unload.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dataload_pkg.sv
// ---------------------------------------------------------------------------
// dataload_pkg : shared framing constants and unload FSM state type  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package dataload_pkg;

  localparam int WORD_W      = 32;
  localparam int FRAME_WORDS = 8;

  typedef enum logic {IDLE, SEND} unload_state_e;

endpackage

`default_nettype wire

// File: rtl/piso_buffer.sv
// ---------------------------------------------------------------------------
// piso_buffer : parallel-load, shift-right, zero-fill frame register  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module piso_buffer #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_en,
  input  logic                            shift_en,
  input  logic                            clear,
  input  logic [WORD_WIDTH*NUM_WORDS-1:0] data_i,
  output logic [WORD_WIDTH-1:0]           data_o
);

  localparam int FRAME_W = WORD_WIDTH * NUM_WORDS;

  logic [FRAME_W-1:0] shift_q;

  // clear outranks load so an abort can never be overridden by a new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if (clear) begin
      shift_q <= '0;
    end else if (load_en) begin
      shift_q <= data_i;
    end else if (shift_en) begin
      shift_q <= shift_q >> WORD_WIDTH;
    end
  end

  assign data_o = shift_q[WORD_WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/result_unload.sv
// ---------------------------------------------------------------------------
// result_unload : serialises a wide result frame onto a valid/ready word bus  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module result_unload
  import dataload_pkg::*;
#(
  parameter int  WORD_WIDTH = WORD_W,
  parameter int  NUM_WORDS  = FRAME_WORDS,
  localparam int CNT_WIDTH  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WORD_WIDTH*NUM_WORDS-1:0] result_i,
  input  logic                            result_valid_i,
  output logic                            result_ready_o,
  input  logic                            flush_i,
  output logic [WORD_WIDTH-1:0]           data_o,
  output logic                            data_valid_o,
  input  logic                            data_ready_i,
  output logic                            last_o,
  output logic [CNT_WIDTH-1:0]            word_idx_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_WORDS - 1);

  unload_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0]   idx_q;
  logic                   done_q;
  logic                   beat, final_beat, capture;

  assign data_valid_o = (state_q == SEND);
  assign busy_o       = (state_q == SEND);
  assign last_o       = data_valid_o && (idx_q == LAST_IDX);
  assign word_idx_o   = idx_q;
  assign done_o       = done_q;

  assign beat       = data_valid_o && data_ready_i;
  assign final_beat = beat && last_o;

  // Ready opens on the final beat so the next frame follows without a bubble
  assign result_ready_o = !flush_i && ((state_q == IDLE) || final_beat);
  assign capture        = result_valid_i && result_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = SEND;
      SEND:    if (final_beat && !capture) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= final_beat && !flush_i;
      if (flush_i || capture || final_beat) begin
        idx_q <= '0;
      end else if (beat) begin
        idx_q <= idx_q + CNT_WIDTH'(1);
      end
    end
  end

  piso_buffer #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_WORDS  (NUM_WORDS)
  ) u_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (capture),
    .shift_en (beat),
    .clear    (flush_i),
    .data_i   (result_i),
    .data_o   (data_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_result_unload.sv
// ---------------------------------------------------------------------------
// tb_result_unload : directed self-checking bench for result_unload  (rev 1.0)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_result_unload;

  localparam int WW = 32;
  localparam int NW = 8;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WW*NW-1:0]  result_i = '0;
  logic              result_valid_i = 1'b0;
  logic              result_ready_o;
  logic              flush_i = 1'b0;
  logic [WW-1:0]     data_o;
  logic              data_valid_o;
  logic              data_ready_i = 1'b0;
  logic              last_o;
  logic [CW-1:0]     word_idx_o;
  logic              busy_o;
  logic              done_o;

  int checks = 0;
  int errors = 0;

  result_unload dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .result_i       (result_i),
    .result_valid_i (result_valid_i),
    .result_ready_o (result_ready_o),
    .flush_i        (flush_i),
    .data_o         (data_o),
    .data_valid_o   (data_valid_o),
    .data_ready_i   (data_ready_i),
    .last_o         (last_o),
    .word_idx_o     (word_idx_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [WW*NW-1:0] make_frame(input logic [31:0] base);
    logic [WW*NW-1:0] f;
    for (int i = 0; i < NW; i++) f[i*WW +: WW] = base + 32'(i);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (data_valid_o !== 1'b0 || data_o !== '0 || word_idx_o !== '0 || last_o !== 1'b0 ||
        busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h idx=%0d last=%b busy=%b done=%b, required all 0",
               data_valid_o, data_o, word_idx_o, last_o, busy_o, done_o);
    end
    #12 rst_n = 1'b1;
    checks++;
    if (result_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", result_ready_o);
    end
    tick();
  endtask

  task automatic test_basic();
    result_i = make_frame(32'h1); result_valid_i = 1'b1; data_ready_i = 1'b1;
    tick();
    result_valid_i = 1'b0;
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (data_valid_o !== 1'b1 || data_o !== 32'(i + 1) || word_idx_o !== CW'(i)) begin
        errors++;
        $display("FAIL basic_word[%0d]: got valid=%b data=%h idx=%0d required 1/%h/%0d",
                 i, data_valid_o, data_o, word_idx_o, 32'(i + 1), i);
      end
      checks++;
      if (last_o !== (i == NW - 1) || done_o !== 1'b0) begin
        errors++;
        $display("FAIL basic_last[%0d]: got last=%b done=%b required %b/0", i, last_o, done_o, (i == NW - 1));
      end
      tick();
    end
    checks++;
    if (done_o !== 1'b1 || data_valid_o !== 1'b0 || data_o !== '0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: got done=%b valid=%b data=%h busy=%b required 1/0/0/0",
               done_o, data_valid_o, data_o, busy_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got %b required 0", done_o);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] pat;
    int ei;
    int cyc;
    pat = 6'b101001;
    ei = 0; cyc = 0;
    result_i = make_frame(32'h11); result_valid_i = 1'b1; data_ready_i = 1'b0;
    tick();
    result_valid_i = 1'b0;
    while (ei < NW && cyc < 60) begin
      checks++;
      if (data_valid_o !== 1'b1 || data_o !== 32'h11 + 32'(ei) || word_idx_o !== CW'(ei) ||
          last_o !== (ei == NW - 1)) begin
        errors++;
        $display("FAIL bp_word cyc %0d: got valid=%b data=%h idx=%0d last=%b required 1/%h/%0d/%b",
                 cyc, data_valid_o, data_o, word_idx_o, last_o, 32'h11 + 32'(ei), ei, (ei == NW - 1));
      end
      data_ready_i = pat[cyc % 6];
      if (data_ready_i) ei++;
      cyc++;
      tick();
    end
    data_ready_i = 1'b1;
    checks++;
    if (ei != NW) begin
      errors++;
      $display("FAIL bp_beats: got %0d beats required %0d", ei, NW);
    end
    checks++;
    if (done_o !== 1'b1 || data_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: got done=%b valid=%b required 1/0", done_o, data_valid_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    data_ready_i = 1'b1;
    result_i = make_frame(32'hA0); result_valid_i = 1'b1;
    tick();
    result_i = make_frame(32'hB0);
    for (int i = 0; i < 2 * NW; i++) begin
      if (i == NW) result_valid_i = 1'b0;
      checks++;
      if (data_valid_o !== 1'b1 || word_idx_o !== CW'(i % NW) ||
          data_o !== ((i < NW) ? 32'hA0 + 32'(i) : 32'hB0 + 32'(i - NW))) begin
        errors++;
        $display("FAIL b2b_word[%0d]: got valid=%b data=%h idx=%0d", i, data_valid_o, data_o, word_idx_o);
      end
      checks++;
      if (done_o !== (i == NW) || result_ready_o !== (i % NW == NW - 1)) begin
        errors++;
        $display("FAIL b2b_ctrl[%0d]: got done=%b ready=%b required %b/%b",
                 i, done_o, result_ready_o, (i == NW), (i % NW == NW - 1));
      end
      if (done_o) dones++;
      tick();
    end
    if (done_o) dones++;
    checks++;
    if (dones != 2 || data_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d dones valid=%b required 2/0", dones, data_valid_o);
    end
    tick();
  endtask

  task automatic test_flush();
    data_ready_i = 1'b1;
    result_i = make_frame(32'h1); result_valid_i = 1'b1;
    tick();
    result_valid_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (data_o !== 32'h4 || word_idx_o !== CW'(3)) begin
      errors++;
      $display("FAIL flush_pre: got data=%h idx=%0d required 4/3", data_o, word_idx_o);
    end
    flush_i = 1'b1; result_i = make_frame(32'hC0); result_valid_i = 1'b1;
    #1;
    checks++;
    if (result_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b required 0", result_ready_o);
    end
    tick();
    flush_i = 1'b0; result_valid_i = 1'b0;
    checks++;
    if (data_valid_o !== 1'b0 || busy_o !== 1'b0 || word_idx_o !== '0 || data_o !== '0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: got valid=%b busy=%b idx=%0d data=%h done=%b required all 0",
               data_valid_o, busy_o, word_idx_o, data_o, done_o);
    end
    tick();
    checks++;
    if (data_valid_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_capture: got valid=%b done=%b required 0/0", data_valid_o, done_o);
    end
    result_i = make_frame(32'hD0); result_valid_i = 1'b1;
    tick();
    result_valid_i = 1'b0;
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (data_valid_o !== 1'b1 || data_o !== 32'hD0 + 32'(i) || word_idx_o !== CW'(i)) begin
        errors++;
        $display("FAIL flush_next[%0d]: got valid=%b data=%h idx=%0d required 1/%h/%0d",
                 i, data_valid_o, data_o, word_idx_o, 32'hD0 + 32'(i), i);
      end
      tick();
    end
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_next_done: got %b required 1", done_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    data_ready_i = 1'b1;
    result_i = make_frame(32'hE0); result_valid_i = 1'b1;
    tick();
    result_valid_i = 1'b0;
    repeat (5) tick();
    checks++;
    if (data_o !== 32'hE5 || word_idx_o !== CW'(5)) begin
      errors++;
      $display("FAIL rstmid_pre: got data=%h idx=%0d required e5/5", data_o, word_idx_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data_valid_o !== 1'b0 || data_o !== '0 || word_idx_o !== '0 || last_o !== 1'b0 ||
        busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got valid=%b data=%h idx=%0d last=%b busy=%b done=%b required all 0",
               data_valid_o, data_o, word_idx_o, last_o, busy_o, done_o);
    end
    #2 rst_n = 1'b1;
    checks++;
    if (result_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: got %b required 1", result_ready_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || data_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_nodone: got done=%b valid=%b required 0/0", done_o, data_valid_o);
    end
    result_i = make_frame(32'hF0); result_valid_i = 1'b1;
    tick();
    result_valid_i = 1'b0;
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (data_valid_o !== 1'b1 || data_o !== 32'hF0 + 32'(i) || word_idx_o !== CW'(i)) begin
        errors++;
        $display("FAIL rstmid_next[%0d]: got valid=%b data=%h idx=%0d required 1/%h/%0d",
                 i, data_valid_o, data_o, word_idx_o, 32'hF0 + 32'(i), i);
      end
      tick();
    end
    tick();
  endtask

  task automatic test_ignored();
    data_ready_i = 1'b1;
    result_i = make_frame(32'h1); result_valid_i = 1'b1;
    tick();
    result_valid_i = 1'b0;
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (data_valid_o !== 1'b1 || data_o !== 32'(i + 1) || word_idx_o !== CW'(i)) begin
        errors++;
        $display("FAIL ign_word[%0d]: got valid=%b data=%h idx=%0d required 1/%h/%0d",
                 i, data_valid_o, data_o, word_idx_o, 32'(i + 1), i);
      end
      if (i == 2) begin
        result_i = make_frame(32'hFF00); result_valid_i = 1'b1;
        #1;
        checks++;
        if (result_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL ign_ready: got %b required 0", result_ready_o);
        end
      end
      if (i == 3) result_valid_i = 1'b0;
      tick();
    end
    checks++;
    if (done_o !== 1'b1 || data_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ign_end: got done=%b valid=%b required 1/0", done_o, data_valid_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
